// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake on both sides.
// Holds one decoded instruction, raises a combinational load-use hazard
// flag against the held load, inserts a single bubble when the load leaves,
// honours a synchronous flush and keeps a saturating stall-cycle count.
module id_ex_stage #(
  parameter int XLEN        = 32,
  parameter int CTRL_WIDTH  = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [CTRL_WIDTH-1:0]  i_ctrl,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [2*XLEN-1:0]      i_rs_data,
  input  logic [XLEN-1:0]        i_imm,
  input  logic [14:0]            i_regs,
  input  logic [3:0]             i_funct,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CTRL_WIDTH-1:0]  o_ctrl,
  output logic [XLEN-1:0]        o_pc,
  output logic [2*XLEN-1:0]      o_rs_data,
  output logic [XLEN-1:0]        o_imm,
  output logic [14:0]            o_regs,
  output logic [3:0]             o_funct,
  output logic                   o_load_use,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  // control word bit carrying the memory-read (load) flag
  localparam int MEM_RE_BIT = 3;

  logic [4:0] rd_held;
  logic [4:0] rs1_in;
  logic [4:0] rs2_in;
  logic       capture;

  assign rd_held = o_regs[4:0];
  assign rs1_in  = i_regs[14:10];
  assign rs2_in  = i_regs[9:5];

  // Conservative hazard: both source fields are compared whatever the opcode.
  assign o_load_use = i_valid & o_valid & o_ctrl[MEM_RE_BIT] & (rd_held != 5'd0) &
                      ((rd_held == rs1_in) | (rd_held == rs2_in));

  // Flush always frees the slot; otherwise accept when not hazarded and the
  // slot is empty or draining this cycle. Held low throughout reset.
  assign o_ready = i_rst_n & (i_flush | (~o_load_use & (~o_valid | i_ready)));

  // A flush never captures, even though o_ready is high during it.
  assign capture = i_valid & o_ready & ~i_flush;

  // Valid bit and control word; ctrl is zeroed whenever the slot empties so a
  // bubble cannot write the register file or memory.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end else if (o_load_use && i_ready) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end else if (capture) begin
      o_valid <= 1'b1;
      o_ctrl  <= i_ctrl;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
      o_ctrl  <= '0;
    end
  end

  // Remaining payload only loads on capture; it is don't-care while invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc      <= '0;
      o_rs_data <= '0;
      o_imm     <= '0;
      o_regs    <= '0;
      o_funct   <= '0;
    end else if (capture) begin
      o_pc      <= i_pc;
      o_rs_data <= i_rs_data;
      o_imm     <= i_imm;
      o_regs    <= i_regs;
      o_funct   <= i_funct;
    end
  end

  // Saturating count of load-use stall cycles; a flush cycle does not count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (o_load_use && !i_flush && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: scoreboard queue of accepted instructions plus a
// small reference model of the slot, hazard flag and stall counter.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int CW   = 16;
  localparam int SW_W = 4;

  localparam logic [15:0] C_ADD = 16'h00C2;
  localparam logic [15:0] C_LW  = 16'h000B;
  localparam logic [15:0] C_SW  = 16'h0024;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [CW-1:0]   i_ctrl;
  logic [XLEN-1:0] i_pc;
  logic [63:0]     i_rs_data;
  logic [XLEN-1:0] i_imm;
  logic [14:0]     i_regs;
  logic [3:0]      i_funct;
  logic            o_valid;
  logic            i_ready;
  logic [CW-1:0]   o_ctrl;
  logic [XLEN-1:0] o_pc;
  logic [63:0]     o_rs_data;
  logic [XLEN-1:0] o_imm;
  logic [14:0]     o_regs;
  logic [3:0]      o_funct;
  logic            o_load_use;
  logic [SW_W-1:0] o_stall_cnt;

  id_ex_stage #(.XLEN(XLEN), .CTRL_WIDTH(CW), .STALL_CNT_W(SW_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_ctrl(i_ctrl), .i_pc(i_pc), .i_rs_data(i_rs_data), .i_imm(i_imm),
    .i_regs(i_regs), .i_funct(i_funct),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_ctrl(o_ctrl), .o_pc(o_pc), .o_rs_data(o_rs_data), .o_imm(o_imm),
    .o_regs(o_regs), .o_funct(o_funct),
    .o_load_use(o_load_use), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct packed {
    logic [15:0] ctrl;
    logic [31:0] pc;
    logic [63:0] rs;
    logic [31:0] imm;
    logic [14:0] regs;
    logic [3:0]  funct;
  } item_t;

  item_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic        m_valid;
  logic [4:0]  m_rd;
  logic        m_memre;
  logic [3:0]  m_cnt;
  logic [31:0] pc_ctr;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [14:0] regs(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd);
    return {rs1, rs2, rd};
  endfunction

  // One clock cycle with inputs already driven: check against model, then
  // advance the model across the edge.
  task automatic step();
    logic  e_lu, e_rdy, consume, accept;
    item_t cur;
    #1;
    e_lu  = i_valid & m_valid & m_memre & (m_rd != 5'd0) &
            ((m_rd == i_regs[14:10]) | (m_rd == i_regs[9:5]));
    e_rdy = i_flush | (~e_lu & (~m_valid | i_ready));
    chk("ready", o_ready, e_rdy);
    chk("load_use", o_load_use, e_lu);
    chk("valid", o_valid, m_valid);
    chk("stall_cnt", o_stall_cnt, m_cnt);
    if (m_valid) begin
      if (q.size() == 0) chk("queue_nonempty", 0, 1);
      else chk("payload", {o_ctrl, o_pc, o_rs_data, o_imm, o_regs, o_funct}, q[0]);
    end else begin
      chk("ctrl_zero", o_ctrl, 0);
    end
    cur = '{ctrl: i_ctrl, pc: i_pc, rs: i_rs_data, imm: i_imm, regs: i_regs, funct: i_funct};
    consume = m_valid & i_ready & ~i_flush;
    accept  = i_valid & e_rdy & ~i_flush;
    @(posedge i_clk);
    if ((consume || (m_valid && i_flush)) && q.size() > 0) void'(q.pop_front());
    if (accept) q.push_back(cur);
    if (e_lu && !i_flush && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    if (i_flush) m_valid = 1'b0;
    else if (e_lu && i_ready) m_valid = 1'b0;
    else if (accept) begin
      m_valid = 1'b1;
      m_rd    = i_regs[4:0];
      m_memre = i_ctrl[3];
    end else if (consume) m_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [14:0] r,
                       input logic f, input logic rdy);
    i_valid   = v;
    i_ctrl    = c;
    i_regs    = r;
    i_flush   = f;
    i_ready   = rdy;
    i_pc      = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
    i_rs_data = {$urandom, $urandom};
    i_imm     = $urandom;
    i_funct   = 4'($urandom_range(0, 15));
    step();
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 15'h0, 1'b0, 1'b1);
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_rd    = 5'd0;
    m_memre = 1'b0;
    m_cnt   = 4'd0;
    q.delete();
  endtask

  task automatic reset_pulse();
    i_rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    pc_ctr    = 32'h1000;
    i_rst_n   = 1'b0;
    i_flush   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_ctrl    = '0;
    i_pc      = '0;
    i_rs_data = '0;
    i_imm     = '0;
    i_regs    = '0;
    i_funct   = '0;
    model_clear();
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_cnt", o_stall_cnt, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // streaming
    for (int i = 0; i < 4; i++) drive(1'b1, C_ADD, regs(5'd6, 5'd7, 5'(i + 1)), 1'b0, 1'b1);
    idle();
    idle();

    // backpressure
    drive(1'b1, C_ADD, regs(5'd1, 5'd2, 5'd10), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, C_ADD, regs(5'd1, 5'd2, 5'd11), 1'b0, 1'b0);
    drive(1'b1, C_ADD, regs(5'd1, 5'd2, 5'd11), 1'b0, 1'b1);
    idle();
    idle();

    // load-use on rs1
    drive(1'b1, C_LW, regs(5'd1, 5'd0, 5'd5), 1'b0, 1'b1);
    drive(1'b1, C_ADD, regs(5'd5, 5'd2, 5'd6), 1'b0, 1'b1);
    chk("lu_bubble_valid", o_valid, 0);
    chk("lu_bubble_ctrl", o_ctrl, 0);
    chk("lu_cnt", o_stall_cnt, 1);
    drive(1'b1, C_ADD, regs(5'd5, 5'd2, 5'd6), 1'b0, 1'b1);
    chk("lu_issue_valid", o_valid, 1);
    chk("lu_issue_ctrl", o_ctrl, C_ADD);
    idle();

    // rd = x0 never stalls
    drive(1'b1, C_LW, regs(5'd1, 5'd0, 5'd0), 1'b0, 1'b1);
    drive(1'b1, C_ADD, regs(5'd0, 5'd0, 5'd6), 1'b0, 1'b1);
    chk("x0_valid", o_valid, 1);
    chk("x0_cnt", o_stall_cnt, 1);
    idle();

    // flush with held SW and incoming instruction
    drive(1'b1, C_SW, regs(5'd1, 5'd2, 5'd0), 1'b0, 1'b1);
    drive(1'b1, C_ADD, regs(5'd3, 5'd4, 5'd7), 1'b1, 1'b0);
    chk("flush_valid", o_valid, 0);
    chk("flush_ctrl", o_ctrl, 0);
    chk("flush_ready", o_ready, 1);
    idle();

    // flush wins over load-use; counter holds
    drive(1'b1, C_LW, regs(5'd1, 5'd0, 5'd5), 1'b0, 1'b1);
    drive(1'b1, C_ADD, regs(5'd5, 5'd0, 5'd6), 1'b1, 1'b1);
    chk("flush_lu_cnt", o_stall_cnt, 1);
    chk("flush_lu_valid", o_valid, 0);
    idle();

    // async reset mid-stream with valid held and count = 7
    reset_pulse();
    drive(1'b1, C_LW, regs(5'd1, 5'd0, 5'd9), 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, C_ADD, regs(5'd3, 5'd9, 5'd4), 1'b0, 1'b0);
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_cnt", o_stall_cnt, 7);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_ctrl", o_ctrl, 0);
    chk("async_pc", o_pc, 0);
    chk("async_cnt", o_stall_cnt, 0);
    chk("async_ready", o_ready, 0);
    model_clear();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b1, C_ADD, regs(5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_ctrl", o_ctrl, C_ADD);
    idle();

    // saturation of the 4-bit counter
    drive(1'b1, C_LW, regs(5'd1, 5'd0, 5'd3), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, C_ADD, regs(5'd3, 5'd3, 5'd8), 1'b0, 1'b0);
    chk("sat_cnt", o_stall_cnt, 15);
    drive(1'b1, C_ADD, regs(5'd3, 5'd3, 5'd8), 1'b0, 1'b1);
    chk("sat_hold", o_stall_cnt, 15);
    drive(1'b1, C_ADD, regs(5'd3, 5'd3, 5'd8), 1'b0, 1'b1);
    idle();
    idle();

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
